vcve2_vrf_sequencer: RTL and testbench

Element-wise sequencer for vector arithmetic in the vcve2 core. It takes one decoded OPCODE_OP_V instruction (vs1, vs2, vd, vl, vsew) and walks the vector register file word by word. For each word it reads the source operands, hands them to the ALU, and writes the result back with tail-undisturbed byte enables. It sits between the ID stage and the shared single-port VRF, and drives the VRF through the `vrf_state_t` state encoding.

---
 rtl/vcve2_vrf_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_vcve2_vrf_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcve2_vrf_sequencer.sv
// Element-wise sequencer for vcve2 vector ops: walks vs1/vs2/(vd) word by word
// through the shared single-port VRF, feeds the ALU and writes results back.
module vcve2_vrf_sequencer #(
    parameter  int unsigned VLEN     = 128,
    localparam int unsigned WPR      = VLEN / 32,
    localparam int unsigned LOG2_WPR = $clog2(WPR),
    localparam int unsigned VRF_AW   = 5 + LOG2_WPR
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [4:0]        vs1_i,
    input  logic [4:0]        vs2_i,
    input  logic [4:0]        vd_i,
    input  logic [15:0]       vl_i,
    input  logic [2:0]        vsew_i,
    input  logic              three_op_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              illegal_o,
    output logic              vrf_req_o,
    output logic              vrf_we_o,
    output logic [VRF_AW-1:0] vrf_addr_o,
    output logic [3:0]        vrf_be_o,
    output logic [31:0]       vrf_wdata_o,
    input  logic              vrf_gnt_i,
    input  logic [31:0]       vrf_rdata_i,
    output logic [31:0]       op_a_o,
    output logic [31:0]       op_b_o,
    output logic [31:0]       op_c_o,
    output logic              alu_req_o,
    input  logic              alu_valid_i,
    input  logic [31:0]       alu_result_i
);

    typedef enum logic [2:0] {
        VRF_IDLE, VRF_START, VRF_READ1, VRF_READ2,
        VRF_READ3, VRF_WAITBUS, VRF_WRITE, VRF_WAITAGU
    } vrf_state_t;

    typedef enum logic [2:0] {VSEW_8 = 3'd0, VSEW_16 = 3'd1, VSEW_32 = 3'd2} vsew_e;

    typedef enum logic [1:0] {CAP_NONE, CAP_A, CAP_B, CAP_C} cap_sel_t;

    vrf_state_t        state_q, state_d;
    logic [4:0]        vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
    logic [15:0]       vl_q, vl_d;
    logic [2:0]        vsew_q, vsew_d;
    logic              three_op_q, three_op_d;
    logic [VRF_AW-1:0] idx_q, idx_d;
    cap_sel_t          cap_q, cap_d;
    logic [31:0]       op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              alu_req_q, alu_req_d;
    logic              done_q, done_d, illegal_q, illegal_d;

    logic [17:0] bytes, rem;
    logic [15:0] nwords, span;
    logic        sew_ok, illegal, last_word;
    logic [3:0]  be_tail;

    function automatic logic group_ovf(input logic [4:0] base, input logic [15:0] words_m1);
        return (17'(base) + 17'(words_m1)) > 17'd31;
    endfunction

    function automatic logic [VRF_AW-1:0] word_addr(input logic [4:0] r, input logic [VRF_AW-1:0] idx);
        return (VRF_AW'(r) << LOG2_WPR) + idx;
    endfunction

    // Instruction geometry, derived from the latched vl/vsew.
    assign bytes     = {2'b00, vl_q} << vsew_q;
    assign nwords    = 16'((bytes + 18'd3) >> 2);
    assign span      = (nwords - 16'd1) >> LOG2_WPR;
    assign sew_ok    = (vsew_q == VSEW_8) || (vsew_q == VSEW_16) || (vsew_q == VSEW_32);
    assign illegal   = !sew_ok || ((nwords != 16'd0) &&
                       (group_ovf(vs1_q, span) || group_ovf(vs2_q, span) || group_ovf(vd_q, span)));
    assign last_word = (16'(idx_q) == nwords - 16'd1);
    assign rem       = bytes - (18'(idx_q) << 2);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        be_tail = 4'h0;
        if (rem >= 18'd4) begin
            be_tail = 4'hF;
        end else begin
            case (rem[1:0])
                2'd1:    be_tail = 4'b0001;
                2'd2:    be_tail = 4'b0011;
                2'd3:    be_tail = 4'b0111;
                default: be_tail = 4'b0000;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= VRF_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs1_q      <= '0;
            vs2_q      <= '0;
            vd_q       <= '0;
            vl_q       <= '0;
            vsew_q     <= '0;
            three_op_q <= 1'b0;
            idx_q      <= '0;
            cap_q      <= CAP_NONE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_c_q     <= '0;
            wdata_q    <= '0;
            alu_req_q  <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            vd_q       <= vd_d;
            vl_q       <= vl_d;
            vsew_q     <= vsew_d;
            three_op_q <= three_op_d;
            idx_q      <= idx_d;
            cap_q      <= cap_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_c_q     <= op_c_d;
            wdata_q    <= wdata_d;
            alu_req_q  <= alu_req_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        vd_d       = vd_q;
        vl_d       = vl_q;
        vsew_d     = vsew_q;
        three_op_d = three_op_q;
        idx_d      = idx_q;
        cap_d      = CAP_NONE;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_c_d     = op_c_q;
        wdata_d    = wdata_q;
        alu_req_d  = 1'b0;
        done_d     = 1'b0;
        illegal_d  = 1'b0;

        // Read data arrives one cycle after its grant, whatever state we are in by then.
        case (cap_q)
            CAP_A:   op_a_d = vrf_rdata_i;
            CAP_B:   op_b_d = vrf_rdata_i;
            CAP_C:   op_c_d = vrf_rdata_i;
            default: ;
        endcase

        case (state_q)
            VRF_IDLE, VRF_WAITAGU: begin
                if (start_i) begin
                    vs1_d      = vs1_i;
                    vs2_d      = vs2_i;
                    vd_d       = vd_i;
                    vl_d       = vl_i;
                    vsew_d     = vsew_i;
                    three_op_d = three_op_i;
                    idx_d      = '0;
                    state_d    = VRF_START;
                end
            end
            VRF_START: begin
                if (illegal) begin
                    illegal_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = VRF_IDLE;
                end else if (nwords == 16'd0) begin
                    done_d    = 1'b1;
                    state_d   = VRF_IDLE;
                end else begin
                    state_d   = VRF_READ1;
                end
            end
            VRF_READ1: if (vrf_gnt_i) begin
                cap_d   = CAP_A;
                state_d = VRF_READ2;
            end
            VRF_READ2: if (vrf_gnt_i) begin
                cap_d   = CAP_B;
                state_d = three_op_q ? VRF_READ3 : VRF_WAITBUS;
            end
            VRF_READ3: if (vrf_gnt_i) begin
                cap_d   = CAP_C;
                state_d = VRF_WAITBUS;
            end
            VRF_WAITBUS: begin
                // The first WAITBUS cycle is the last capture, so alu_req rises one cycle later.
                if (alu_req_q && alu_valid_i) begin
                    wdata_d = alu_result_i;
                    state_d = VRF_WRITE;
                end else begin
                    alu_req_d = 1'b1;
                end
            end
            VRF_WRITE: if (vrf_gnt_i) begin
                if (last_word) begin
                    done_d  = 1'b1;
                    state_d = VRF_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = VRF_READ1;
                end
            end
            default: state_d = VRF_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != VRF_IDLE) && (state_q != VRF_WAITAGU);
        vrf_req_o  = 1'b0;
        vrf_we_o   = 1'b0;
        vrf_addr_o = '0;
        vrf_be_o   = 4'h0;
        case (state_q)
            VRF_READ1: begin
                vrf_req_o  = 1'b1;
                vrf_addr_o = word_addr(vs1_q, idx_q);
            end
            VRF_READ2: begin
                vrf_req_o  = 1'b1;
                vrf_addr_o = word_addr(vs2_q, idx_q);
            end
            VRF_READ3: begin
                vrf_req_o  = 1'b1;
                vrf_addr_o = word_addr(vd_q, idx_q);
            end
            VRF_WRITE: begin
                vrf_req_o  = 1'b1;
                vrf_we_o   = 1'b1;
                vrf_addr_o = word_addr(vd_q, idx_q);
                vrf_be_o   = be_tail;
            end
            default: ;
        endcase
    end

    assign done_o      = done_q;
    assign illegal_o   = illegal_q;
    assign vrf_wdata_o = wdata_q;
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign op_c_o      = op_c_q;
    assign alu_req_o   = alu_req_q;

endmodule

// File: tb/tb_vcve2_vrf_sequencer.sv
// Randomized bench for vcve2_vrf_sequencer: a VRF/ALU responder plus a
// word-by-word reference model of the vector operation.
`timescale 1ns/1ps
module tb_vcve2_vrf_sequencer;

    localparam int VLEN = 128;
    localparam int WPR  = VLEN / 32;
    localparam int AW   = 5 + $clog2(WPR);
    localparam int NW   = 32 * WPR;

    logic          clk_i, rst_ni, start_i, three_op_i;
    logic [4:0]    vs1_i, vs2_i, vd_i;
    logic [15:0]   vl_i;
    logic [2:0]    vsew_i;
    logic          busy_o, done_o, illegal_o, vrf_req_o, vrf_we_o;
    logic [AW-1:0] vrf_addr_o;
    logic [3:0]    vrf_be_o;
    logic [31:0]   vrf_wdata_o, vrf_rdata_i, op_a_o, op_b_o, op_c_o, alu_result_i;
    logic          vrf_gnt_i, alu_req_o, alu_valid_i;

    vcve2_vrf_sequencer #(.VLEN(VLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i), .vl_i(vl_i), .vsew_i(vsew_i),
        .three_op_i(three_op_i), .busy_o(busy_o), .done_o(done_o), .illegal_o(illegal_o),
        .vrf_req_o(vrf_req_o), .vrf_we_o(vrf_we_o), .vrf_addr_o(vrf_addr_o),
        .vrf_be_o(vrf_be_o), .vrf_wdata_o(vrf_wdata_o), .vrf_gnt_i(vrf_gnt_i),
        .vrf_rdata_i(vrf_rdata_i), .op_a_o(op_a_o), .op_b_o(op_b_o), .op_c_o(op_c_o),
        .alu_req_o(alu_req_o), .alu_valid_i(alu_valid_i), .alu_result_i(alu_result_i)
    );

    typedef struct {
        int          addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0, n_fail = 0, cyc = 0;
    logic [31:0] mem [NW];
    logic [31:0] ref_mem [NW];
    wr_t         wr_log[$];
    int          rd_log[$];
    int          gnt_mode = 0, alu_mode = 0, stall_left = 0, stall_addr = -1;
    logic        cur_t3 = 1'b0;
    int          done_cnt = 0, illegal_cnt = 0, done_cyc = 0, illegal_cyc = 0, req_cnt = 0;

    function automatic logic [31:0] alu_f(input logic [31:0] a, b, c, input logic t3);
        return t3 ? ((a + b) ^ c) : (a + b);
    endfunction

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc = cyc + 1;
    end

    // VRF + ALU responder and bus monitor, all acting mid-cycle on the falling edge.
    initial begin : responder
        logic          pend_rd, prev_stall, prev_alu;
        int            pend_addr, alu_hi;
        logic [AW+37:0] cur_bus, prev_bus;
        logic [95:0]   cur_ops, prev_ops;
        pend_rd = 0; prev_stall = 0; prev_alu = 0; pend_addr = 0; alu_hi = 0;
        prev_bus = '0; prev_ops = '0;
        vrf_gnt_i = 0; alu_valid_i = 0; vrf_rdata_i = '0; alu_result_i = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                pend_rd = 0; prev_stall = 0; prev_alu = 0; alu_hi = 0;
                vrf_gnt_i = 0; alu_valid_i = 0; vrf_rdata_i = '0;
            end else begin
                vrf_rdata_i = pend_rd ? mem[pend_addr] : $urandom();
                pend_rd = 0;
                cur_bus = {vrf_req_o, vrf_we_o, vrf_addr_o, vrf_be_o, vrf_wdata_o};
                if (prev_stall) begin
                    n_checks++;
                    if (cur_bus !== prev_bus) begin
                        n_fail++;
                        $display("FAIL bus_stable_on_stall: got %h, required %h", cur_bus, prev_bus);
                    end
                end
                cur_ops = {op_a_o, op_b_o, op_c_o};
                if (prev_alu && alu_req_o) begin
                    n_checks++;
                    if (cur_ops !== prev_ops) begin
                        n_fail++;
                        $display("FAIL operands_stable: got %h, required %h", cur_ops, prev_ops);
                    end
                end
                case (gnt_mode)
                    0: vrf_gnt_i = 1'b1;
                    1: vrf_gnt_i = ($urandom_range(0, 2) != 0);
                    default: begin
                        if (vrf_req_o && !vrf_we_o && int'(vrf_addr_o) == stall_addr && stall_left > 0) begin
                            vrf_gnt_i = 1'b0;
                            stall_left--;
                        end else begin
                            vrf_gnt_i = 1'b1;
                        end
                    end
                endcase
                alu_result_i = alu_f(op_a_o, op_b_o, op_c_o, cur_t3);
                case (alu_mode)
                    0:       alu_valid_i = 1'b1;
                    1:       alu_valid_i = 1'($urandom_range(0, 1));
                    default: alu_valid_i = alu_req_o && (alu_hi >= 2);
                endcase
                alu_hi = alu_req_o ? alu_hi + 1 : 0;
                if (vrf_req_o && vrf_gnt_i) begin
                    if (vrf_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (vrf_be_o[b]) mem[int'(vrf_addr_o)][8*b +: 8] = vrf_wdata_o[8*b +: 8];
                        wr_log.push_back('{addr: int'(vrf_addr_o), be: vrf_be_o, data: vrf_wdata_o});
                    end else begin
                        pend_rd   = 1;
                        pend_addr = int'(vrf_addr_o);
                        rd_log.push_back(pend_addr);
                    end
                end
                prev_stall = vrf_req_o && !vrf_gnt_i;
                prev_bus   = cur_bus;
                prev_alu   = alu_req_o;
                prev_ops   = cur_ops;
            end
            if (vrf_req_o)  req_cnt++;
            if (done_o)     begin done_cnt++; done_cyc = cyc; end
            if (illegal_o)  begin illegal_cnt++; illegal_cyc = cyc; end
        end
    end

    // Issues one instruction and checks it against a sequential per-word model.
    task automatic run_op(input int s1, s2, d, vl, sew, input bit t3, input bit noise, input string tag);
        int  bytes, nw, base_cyc, exp_cyc, rem, bad;
        bit  legal, timed_out, ok;
        int  exp_rd[$];
        wr_t exp_wr[$];
        logic [31:0] a, b, c, r;
        logic [3:0]  be;
        bytes = vl << sew;
        nw    = (bytes + 3) / 4;
        legal = (sew <= 2) && (nw == 0 ||
                ((s1 + (nw - 1) / WPR <= 31) && (s2 + (nw - 1) / WPR <= 31) && (d + (nw - 1) / WPR <= 31)));
        ref_mem = mem;
        if (legal) begin
            for (int i = 0; i < nw; i++) begin
                a = ref_mem[s1*WPR + i];
                b = ref_mem[s2*WPR + i];
                c = ref_mem[d*WPR + i];
                r = alu_f(a, b, c, t3);
                rem = bytes - 4*i;
                be = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
                for (int k = 0; k < 4; k++) if (be[k]) ref_mem[d*WPR + i][8*k +: 8] = r[8*k +: 8];
                exp_rd.push_back(s1*WPR + i);
                exp_rd.push_back(s2*WPR + i);
                if (t3) exp_rd.push_back(d*WPR + i);
                exp_wr.push_back('{addr: d*WPR + i, be: be, data: r});
            end
        end
        wr_log.delete(); rd_log.delete();
        done_cnt = 0; illegal_cnt = 0; req_cnt = 0;
        cur_t3 = t3; stall_addr = s2 * WPR;

        @(negedge clk_i);
        vs1_i = 5'(s1); vs2_i = 5'(s2); vd_i = 5'(d); vl_i = 16'(vl); vsew_i = 3'(sew);
        three_op_i = t3; start_i = 1'b1; base_cyc = cyc;
        timed_out = 1;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_cnt != 0) begin timed_out = 0; break; end
            if (noise && busy_o && (k % 5 == 2)) begin
                start_i = 1'b1; vs1_i = 5'($urandom); vs2_i = 5'($urandom); vd_i = 5'($urandom);
                vl_i = 16'($urandom); vsew_i = 3'($urandom); three_op_i = 1'($urandom);
            end
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);

        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL %s timeout: no done_o within 6000 cycles", tag); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL %s done_count: got %0d, required 1", tag, done_cnt); end
        n_checks++;
        if (illegal_cnt != (legal ? 0 : 1)) begin
            n_fail++; $display("FAIL %s illegal_count: got %0d, required %0d", tag, illegal_cnt, legal ? 0 : 1);
        end
        if (!legal) begin
            n_checks++;
            if (illegal_cyc != done_cyc) begin
                n_fail++; $display("FAIL %s illegal_with_done: got cycle %0d, required %0d", tag, illegal_cyc, done_cyc);
            end
        end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_done: got %b, required 0", tag, busy_o); end
        if (gnt_mode == 0 && alu_mode == 0) begin
            exp_cyc = (legal && nw > 0) ? 2 + (t3 ? 6 : 5) * nw : 2;
            n_checks++;
            if (done_cyc - base_cyc != exp_cyc) begin
                n_fail++; $display("FAIL %s done_cycle: got %0d, required %0d", tag, done_cyc - base_cyc, exp_cyc);
            end
        end
        if (!legal || nw == 0) begin
            n_checks++;
            if (req_cnt != 0) begin n_fail++; $display("FAIL %s no_access: got %0d req cycles, required 0", tag, req_cnt); end
        end
        n_checks++;
        if (wr_log.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL %s write_count: got %0d, required %0d", tag, wr_log.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
            n_checks++;
            if (wr_log[i].addr != exp_wr[i].addr || wr_log[i].be !== exp_wr[i].be || wr_log[i].data !== exp_wr[i].data) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got addr %0d be %b data %h, required addr %0d be %b data %h", tag, i,
                         wr_log[i].addr, wr_log[i].be, wr_log[i].data, exp_wr[i].addr, exp_wr[i].be, exp_wr[i].data);
            end
        end
        ok = (rd_log.size() == exp_rd.size());
        for (int i = 0; ok && i < exp_rd.size(); i++) if (rd_log[i] != exp_rd[i]) ok = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s read_sequence: got %0d reads (first %0d), required %0d reads (first %0d)", tag,
                     rd_log.size(), rd_log.size() > 0 ? rd_log[0] : -1, exp_rd.size(), exp_rd.size() > 0 ? exp_rd[0] : -1);
        end
        bad = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL %s vrf_contents: got %0d differing words, required 0", tag, bad); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, illegal_o, vrf_req_o, vrf_we_o, vrf_addr_o, vrf_be_o, vrf_wdata_o,
             op_a_o, op_b_o, op_c_o, alu_req_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero output, required all 0");
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, vrf_req_o, alu_req_o} !== 4'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b, required 0000", {busy_o, done_o, vrf_req_o, alu_req_o});
        end
    endtask

    task automatic test_basic();
        gnt_mode = 0; alu_mode = 0;
        run_op(1, 2, 3, 4, 2, 0, 0, "basic");
        n_checks++;
        if (wr_log.size() != 4 || wr_log[0].addr != 12 || wr_log[3].addr != 15 || wr_log[3].be !== 4'hF) begin
            n_fail++; $display("FAIL basic_write_addrs: got %0d writes, required 4 writes to 12..15 with be F", wr_log.size());
        end
    endtask

    task automatic test_tail();
        gnt_mode = 0; alu_mode = 0;
        run_op(1, 2, 3, 6, 0, 0, 0, "tail");
        n_checks++;
        if (wr_log.size() != 2 || wr_log[1].addr != 13 || wr_log[1].be !== 4'b0011) begin
            n_fail++; $display("FAIL tail_be: got %0d writes, required second write addr 13 be 0011", wr_log.size());
        end
    endtask

    task automatic test_zero_len();
        gnt_mode = 0; alu_mode = 0;
        run_op(1, 2, 3, 0, 2, 0, 0, "zero_len");
    endtask

    task automatic test_illegal();
        gnt_mode = 0; alu_mode = 0;
        run_op(1, 2, 3, 4, 3, 0, 0, "illegal_sew");
        run_op(1, 2, 31, 8, 2, 0, 0, "illegal_vd_ovf");
        run_op(31, 2, 3, 5, 2, 1, 0, "illegal_vs1_ovf");
        run_op(4, 31, 5, 17, 0, 0, 0, "illegal_vs2_ovf");
        run_op(30, 29, 31, 4, 2, 1, 0, "legal_last_reg");
        run_op(5, 6, 31, 16, 0, 0, 0, "legal_last_reg_bytes");
    endtask

    task automatic test_stall_three_op();
        gnt_mode = 2; alu_mode = 2; stall_left = 3;
        run_op(4, 8, 12, 8, 1, 1, 1, "stall_three_op");
        n_checks++;
        if (stall_left != 0) begin n_fail++; $display("FAIL stall_applied: got %0d stall cycles left, required 0", stall_left); end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        gnt_mode = 0; alu_mode = 2; cur_t3 = 0;
        @(negedge clk_i);
        vs1_i = 5'd4; vs2_i = 5'd5; vd_i = 5'd6; vl_i = 16'd8; vsew_i = 3'd2; three_op_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk_i);
            if (alu_req_o) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL reset_mid_reach_waitbus: got no alu_req_o, required one within 50 cycles"); end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, illegal_o, vrf_req_o, vrf_we_o, vrf_addr_o, vrf_be_o, vrf_wdata_o,
             op_a_o, op_b_o, op_c_o, alu_req_o} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got nonzero output, required all 0");
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        done_cnt = 0; req_cnt = 0;
        repeat (40) @(negedge clk_i);
        n_checks++;
        if (done_cnt != 0 || req_cnt != 0) begin
            n_fail++; $display("FAIL reset_mid_no_done: got %0d done, %0d req cycles, required 0 and 0", done_cnt, req_cnt);
        end
        alu_mode = 0;
        run_op(4, 5, 6, 8, 2, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        int s1, s2, d, vl, sew;
        for (int n = 0; n < 30; n++) begin
            gnt_mode = $urandom_range(0, 1);
            alu_mode = $urandom_range(0, 1);
            s1 = $urandom_range(0, 31); s2 = $urandom_range(0, 31); d = $urandom_range(0, 31);
            vl = $urandom_range(0, 40);
            sew = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            run_op(s1, s2, d, vl, sew, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("random%0d", n));
        end
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; vs1_i = '0; vs2_i = '0; vd_i = '0;
        vl_i = '0; vsew_i = '0; three_op_i = 1'b0;
        for (int i = 0; i < NW; i++) mem[i] = $urandom();
        test_reset();
        test_basic();
        test_tail();
        test_zero_len();
        test_illegal();
        test_stall_three_op();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
